gray_to_rgb_colorizer: RTL and testbench

//  Converts a 4-bit grayscale pixel stream back into RGB444 by per-channel tint gain,

---
 rtl/gray_to_rgb_colorizer.sv | 116 +++++++++++
 tb/tb_gray_to_rgb_colorizer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_to_rgb_colorizer.sv
// Grayscale-to-RGB444 colorizer: per-channel tint gain, 2-stage valid/ready pipeline,
// line/frame position flags and a frame-synchronous shadowed tint register.
module gray_to_rgb_colorizer #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_gray,
    input  logic        cfg_we,
    input  logic [11:0] cfg_tint,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_rgb,
    output logic        out_eol,
    output logic        out_eof,
    output logic        tint_pend
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [11:0]   tint_act;
    logic [11:0]   tint_shd;

    logic          s1_valid;
    logic          s1_eol;
    logic          s1_eof;
    logic [7:0]    s1_pr;
    logic [7:0]    s1_pg;
    logic [7:0]    s1_pb;

    logic          en;
    logic          accept;
    logic          x_last;
    logic          y_last;
    logic          apply_tint;
    logic [11:0]   gain;

    // Rescale an 8-bit product back to 4 bits: (p + p/16 + 8) / 16, max 247/16 = 15.
    function automatic logic [3:0] rescale(input logic [7:0] p);
        logic [8:0] sum;
        sum = {1'b0, p} + {5'b0, p[7:4]} + 9'd8;
        return 4'(sum >> 4);
    endfunction

    assign en         = !out_valid || out_ready;
    assign in_ready   = en;
    assign accept     = in_valid && en;
    assign x_last     = (x == XW'(IMG_W - 1));
    assign y_last     = (y == YW'(IMG_H - 1));
    // The first pixel of a frame already uses a pending tint.
    assign apply_tint = accept && tint_pend && (x == '0) && (y == '0);
    assign gain       = apply_tint ? tint_shd : tint_act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            tint_act  <= 12'hFFF;
            tint_shd  <= 12'hFFF;
            tint_pend <= 1'b0;
            s1_valid  <= 1'b0;
            s1_eol    <= 1'b0;
            s1_eof    <= 1'b0;
            s1_pr     <= '0;
            s1_pg     <= '0;
            s1_pb     <= '0;
            out_valid <= 1'b0;
            out_rgb   <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            if (en) begin
                s1_valid  <= accept;
                out_valid <= s1_valid;
                if (accept) begin
                    s1_pr  <= {4'b0, in_gray} * {4'b0, gain[11:8]};
                    s1_pg  <= {4'b0, in_gray} * {4'b0, gain[7:4]};
                    s1_pb  <= {4'b0, in_gray} * {4'b0, gain[3:0]};
                    s1_eol <= x_last;
                    s1_eof <= x_last && y_last;
                end
                if (s1_valid) begin
                    out_rgb <= {rescale(s1_pr), rescale(s1_pg), rescale(s1_pb)};
                    out_eol <= s1_eol;
                    out_eof <= s1_eof;
                end
            end

            if (accept) begin
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end

            if (apply_tint) begin
                tint_act  <= tint_shd;
                tint_pend <= 1'b0;
            end
            // A write landing on the frame-start accept is held for the next frame.
            if (cfg_we) begin
                tint_shd  <= cfg_tint;
                tint_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_to_rgb_colorizer.sv
// Randomized bench for gray_to_rgb_colorizer on a 4x2 image, checked against a
// queue-based reference model of pixel position, tint shadowing and channel scaling.
module tb_gray_to_rgb_colorizer;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_gray;
    logic        cfg_we;
    logic [11:0] cfg_tint;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_rgb;
    logic        out_eol;
    logic        out_eof;
    logic        tint_pend;

    gray_to_rgb_colorizer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gray   (in_gray),
        .cfg_we    (cfg_we),
        .cfg_tint  (cfg_tint),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rgb   (out_rgb),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .tint_pend (tint_pend)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: each channel is gray*gain/15 in spirit, computed as (p + p/16 + 8)/16.
    function automatic logic [3:0] chan(input int g, input int gn);
        int p;
        p = g * gn;
        return 4'((p + p / 16 + 8) / 16);
    endfunction

    typedef struct {
        logic [11:0] rgb;
        logic        eol;
        logic        eof;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          pos;
    int          cyc = 0;
    logic [11:0] m_act;
    logic [11:0] m_shd;
    logic        m_pend;
    logic        chk_lat = 1'b0;
    logic        prev_stall = 1'b0;
    logic [13:0] prev_out;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            sb.delete();
            pos        = 0;
            m_act      = 12'hFFF;
            m_shd      = 12'hFFF;
            m_pend     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
            check("tint_pend", {31'b0, tint_pend}, {31'b0, m_pend});
            if (prev_stall) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_data", {18'b0, out_eol, out_eof, out_rgb}, {18'b0, prev_out});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("extra_pixel", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_rgb", {20'b0, out_rgb}, {20'b0, e.rgb});
                    check("out_eol", {31'b0, out_eol}, {31'b0, e.eol});
                    check("out_eof", {31'b0, out_eof}, {31'b0, e.eof});
                    if (chk_lat) check("latency", cyc - e.cyc, 32'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_eol, out_eof, out_rgb};

            if (in_valid && in_ready) begin
                if (pos == 0 && m_pend) begin
                    m_act  = m_shd;
                    m_pend = 1'b0;
                end
                e.rgb = {chan(in_gray, m_act[11:8]), chan(in_gray, m_act[7:4]),
                         chan(in_gray, m_act[3:0])};
                e.eol = (pos % W) == W - 1;
                e.eof = pos == W * H - 1;
                e.cyc = cyc;
                sb.push_back(e);
                pos = (pos + 1) % (W * H);
            end
            if (cfg_we) begin
                m_shd  = cfg_tint;
                m_pend = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_gray   = '0;
        cfg_we    = 1'b0;
        cfg_tint  = '0;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_rgb", {20'b0, out_rgb}, 32'd0);
        check("rst_flags", {30'b0, out_eol, out_eof}, 32'd0);
        check("rst_tint_pend", {31'b0, tint_pend}, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Identity tint, full-rate stream with exact 2-cycle latency
        chk_lat = 1'b1;
        for (int g = 0; g < 16; g++) begin
            in_valid = 1'b1;
            in_gray  = 4'(g);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk_lat = 1'b0;

        // Tint written before a frame start applies to that frame's first pixel
        cfg_we   = 1'b1;
        cfg_tint = 12'hF80;
        step();
        cfg_we   = 1'b0;
        in_valid = 1'b1;
        in_gray  = 4'd15;
        step();
        in_gray  = 4'd8;
        step();
        in_valid = 1'b0;
        step();

        // Mid-frame write stays pending until the next frame
        cfg_we   = 1'b1;
        cfg_tint = 12'h00F;
        step();
        cfg_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_gray  = 4'($urandom_range(0, 15));
            step();
        end

        // Downstream stall for 5 cycles while input keeps offering
        for (int i = 0; i < 16; i++) begin
            out_ready = !(i >= 4 && i < 9);
            in_gray   = 4'($urandom_range(0, 15));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Reset with both stages full and a tint pending
        cfg_we    = 1'b1;
        cfg_tint  = 12'h123;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_gray   = 4'd9;
        step();
        cfg_we = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_tint_pend", {31'b0, tint_pend}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_gray = 4'($urandom_range(0, 15));
            step();
        end

        // Random traffic with occasional tint writes
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            in_gray   = 4'($urandom);
            cfg_we    = ($urandom % 40) == 0;
            cfg_tint  = 12'($urandom);
            step();
        end

        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check("drain_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
